pc_jump_unit: RTL and testbench

- Execute-side consumer of the jump decoder.
- Owns the architectural PC register. Takes the decoded jump fields (rd, rs1, imm, jump_control) plus the instruction's PC.
- Computes the JAL/JALR target, redirects fetch, produces the link writeback (pc+4), and flushes wrong-path instructions for a fixed number of cycles.
- Sits between decode and fetch/writeback. Reads rs1 from the register file, which has 1-cycle read latency.

---
 rtl/pc_jump_unit_pkg.sv | 24 ++
 rtl/jump_target_calc.sv | 28 ++
 rtl/pc_jump_unit.sv | 139 +++++++++++++
 tb/tb_pc_jump_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_jump_unit_pkg.sv
// Shared definitions for the jump execution path: jump_control encodings, FSM states
// and immediate sign-extension helpers.
package pc_jump_unit_pkg;

    // Mirrors the jump_control encodings of processor_defines.sv.
    localparam logic [1:0] JMP_NOP = 2'b00;
    localparam logic [1:0] JAL     = 2'b01;
    localparam logic [1:0] JALR    = 2'b10;

    typedef enum logic [1:0] {
        StRun,
        StRs1Wait,
        StFlush
    } state_e;

    function automatic logic [31:0] sext21(input logic [20:0] v);
        return {{11{v[20]}}, v};
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational jump target: sign-extend the offset, add to the base, clear the JALR LSB
// and flag targets that are not 4-byte aligned.
module jump_target_calc
    import pc_jump_unit_pkg::*;
(
    input  logic [31:0] i_base,
    input  logic [20:0] i_imm,
    input  logic        i_is_jalr,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    logic [31:0] w_offset;
    logic [31:0] w_sum;

    always_comb begin
        w_offset = i_is_jalr ? sext12(i_imm[11:0]) : sext21(i_imm);
        w_sum    = i_base + w_offset;
        if (i_is_jalr) begin
            o_target     = {w_sum[31:1], 1'b0};
            o_misaligned = w_sum[1];
        end else begin
            o_target     = w_sum;
            o_misaligned = (w_sum[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/pc_jump_unit.sv
// Architectural PC owner: executes JAL/JALR, redirects fetch, emits the link writeback
// and holds flush for a fixed number of cycles after each redirect.
module pc_jump_unit
    import pc_jump_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seq_advance,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst_pc,
    input  logic [4:0]  rd_in,
    input  logic [4:0]  rs1_in,
    input  logic [20:0] imm_in,
    input  logic [1:0]  jump_control,
    output logic [4:0]  rf_rs1_addr,
    input  logic [31:0] rf_rs1_data,
    output logic [31:0] pc,
    output logic        flush,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned_exc
);

    localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

    state_e      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_flush_cnt;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_misaligned;
    logic [31:0] r_link_pc;
    logic [4:0]  r_link_rd;
    logic [20:0] r_imm;

    logic        w_accept;
    logic        w_take_jal;
    logic        w_take_jalr;
    logic        w_in_wait;
    logic [31:0] w_tgt;
    logic        w_tgt_mis;

    always_comb begin
        w_in_wait   = (r_state == StRs1Wait);
        inst_ready  = !w_in_wait;
        w_accept    = inst_valid && inst_ready;
        w_take_jal  = w_accept && (r_state == StRun) && (jump_control == JAL);
        w_take_jalr = w_accept && (r_state == StRun) && (jump_control == JALR);
        rf_rs1_addr = (w_take_jalr && !rst) ? rs1_in : 5'd0;
    end

    // One adder serves JAL in the accept cycle and JALR in the rs1 wait cycle.
    jump_target_calc u_calc (
        .i_base       (w_in_wait ? rf_rs1_data : inst_pc),
        .i_imm        (w_in_wait ? r_imm : imm_in),
        .i_is_jalr    (w_in_wait),
        .o_target     (w_tgt),
        .o_misaligned (w_tgt_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StRun;
            r_pc         <= RESET_PC;
            r_flush_cnt  <= 3'd0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'd0;
            r_misaligned <= 1'b0;
            r_link_pc    <= 32'd0;
            r_link_rd    <= 5'd0;
            r_imm        <= 21'd0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                StRun: begin
                    if (w_take_jal) begin
                        if (w_tgt_mis) begin
                            r_misaligned <= 1'b1;
                            if (seq_advance) r_pc <= r_pc + 32'd4;
                        end else begin
                            r_pc        <= w_tgt;
                            r_wb_valid  <= (rd_in != 5'd0);
                            r_wb_rd     <= rd_in;
                            r_wb_data   <= inst_pc + 32'd4;
                            r_flush_cnt <= FlushLast;
                            r_state     <= StFlush;
                        end
                    end else if (w_take_jalr) begin
                        r_link_pc <= inst_pc;
                        r_link_rd <= rd_in;
                        r_imm     <= imm_in;
                        r_state   <= StRs1Wait;
                    end else if (seq_advance) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                StRs1Wait: begin
                    if (w_tgt_mis) begin
                        r_misaligned <= 1'b1;
                        if (seq_advance) r_pc <= r_pc + 32'd4;
                        r_state <= StRun;
                    end else begin
                        r_pc        <= w_tgt;
                        r_wb_valid  <= (r_link_rd != 5'd0);
                        r_wb_rd     <= r_link_rd;
                        r_wb_data   <= r_link_pc + 32'd4;
                        r_flush_cnt <= FlushLast;
                        r_state     <= StFlush;
                    end
                end
                StFlush: begin
                    if (seq_advance) r_pc <= r_pc + 32'd4;
                    if (r_flush_cnt == 3'd0) begin
                        r_state <= StRun;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    assign pc             = r_pc;
    assign flush          = (r_state == StFlush);
    assign wb_valid       = r_wb_valid;
    assign wb_rd          = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign misaligned_exc = r_misaligned;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Self-checking bench for pc_jump_unit: per-cycle vector table with a scoreboard queue,
// plus hand-written reset-abort sequences.
module tb_pc_jump_unit;
    import pc_jump_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        seq_advance;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [4:0]  rd_in;
    logic [4:0]  rs1_in;
    logic [20:0] imm_in;
    logic [1:0]  jump_control;
    logic [4:0]  rf_rs1_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] pc;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned_exc;

    pc_jump_unit #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .seq_advance    (seq_advance),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .rd_in          (rd_in),
        .rs1_in         (rs1_in),
        .imm_in         (imm_in),
        .jump_control   (jump_control),
        .rf_rs1_addr    (rf_rs1_addr),
        .rf_rs1_data    (rf_rs1_data),
        .pc             (pc),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .misaligned_exc (misaligned_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        seq;
        logic        vld;
        logic [1:0]  jc;
        logic [31:0] ipc;
        logic [20:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] rfd;
    } stim_t;

    // rdy/addr are checked in the drive cycle; the rest after the following edge.
    typedef struct {
        logic        rdy;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic        fl;
        logic        wbv;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        mis;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic stim_t st(input logic seq, input logic vld, input logic [1:0] jc,
                                 input logic [31:0] ipc, input logic [20:0] imm,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [31:0] rfd);
        stim_t s;
        s.seq = seq; s.vld = vld; s.jc = jc; s.ipc = ipc;
        s.imm = imm; s.rd = rd; s.rs1 = rs1; s.rfd = rfd;
        return s;
    endfunction

    function automatic exp_t ex(input logic rdy, input logic [4:0] addr, input logic [31:0] p,
                                input logic fl, input logic wbv, input logic [4:0] wrd,
                                input logic [31:0] wdat, input logic mis);
        exp_t e;
        e.rdy = rdy; e.addr = addr; e.pc = p; e.fl = fl;
        e.wbv = wbv; e.wrd = wrd; e.wdat = wdat; e.mis = mis;
        return e;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        seq_advance  = s.seq;
        inst_valid   = s.vld;
        jump_control = s.jc;
        inst_pc      = s.ipc;
        imm_in       = s.imm;
        rd_in        = s.rd;
        rs1_in       = s.rs1;
        rf_rs1_data  = s.rfd;
    endtask

    function automatic stim_t idle(input logic seq);
        return st(seq, 1'b0, JMP_NOP, 32'h0, 21'h0, 5'd0, 5'd0, 32'h0);
    endfunction

    initial begin
        exp_t  e;
        stim_t far_jal;

        far_jal = st(1'b0, 1'b1, JAL, 32'h2024, 21'h1FE3DC, 5'd4, 5'd0, 32'h0);

        // Sequential fetch
        add(idle(1'b1), ex(1, 5'd0, 32'h4, 0, 0, 5'd0, 32'h0, 0));
        add(idle(1'b1), ex(1, 5'd0, 32'h8, 0, 0, 5'd0, 32'h0, 0));
        add(idle(1'b1), ex(1, 5'd0, 32'hC, 0, 0, 5'd0, 32'h0, 0));
        // JAL -16 from 0x100 with coincident seq_advance
        add(st(1, 1, JAL, 32'h100, 21'h1FFFF0, 5'd1, 5'd0, 32'h0),
            ex(1, 5'd0, 32'hF0, 1, 1, 5'd1, 32'h104, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'hF0, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'hF0, 0, 0, 5'd0, 32'h0, 0));
        // JALR x5 - 4, rd = 0
        add(st(1, 1, JALR, 32'h200, 21'h000FFC, 5'd0, 5'd5, 32'h0),
            ex(1, 5'd5, 32'hF0, 0, 0, 5'd0, 32'h0, 0));
        add(st(1, 0, JMP_NOP, 32'h0, 21'h0, 5'd0, 5'd0, 32'h2001),
            ex(0, 5'd0, 32'h1FFC, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b1), ex(1, 5'd0, 32'h2000, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'h2000, 0, 0, 5'd0, 32'h0, 0));
        // Misaligned JAL
        add(st(1, 1, JAL, 32'h10, 21'h6, 5'd3, 5'd0, 32'h0),
            ex(1, 5'd0, 32'h2004, 0, 0, 5'd0, 32'h0, 1));
        add(idle(1'b0), ex(1, 5'd0, 32'h2004, 0, 0, 5'd0, 32'h0, 0));
        // JAL +0x20, then a JAL to 0x400 presented through the whole flush window
        add(st(0, 1, JAL, 32'h2004, 21'h20, 5'd2, 5'd0, 32'h0),
            ex(1, 5'd0, 32'h2024, 1, 1, 5'd2, 32'h2008, 0));
        add(far_jal, ex(1, 5'd0, 32'h2024, 1, 0, 5'd0, 32'h0, 0));
        add(far_jal, ex(1, 5'd0, 32'h2024, 0, 0, 5'd0, 32'h0, 0));
        add(far_jal, ex(1, 5'd0, 32'h400, 1, 1, 5'd4, 32'h2028, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'h400, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'h400, 0, 0, 5'd0, 32'h0, 0));
        // JALR with target bit1 set
        add(st(1, 1, JALR, 32'h400, 21'h2, 5'd1, 5'd7, 32'h0),
            ex(1, 5'd7, 32'h400, 0, 0, 5'd0, 32'h0, 0));
        add(st(1, 0, JMP_NOP, 32'h0, 21'h0, 5'd0, 5'd0, 32'h100),
            ex(0, 5'd0, 32'h404, 0, 0, 5'd0, 32'h0, 1));
        add(idle(1'b0), ex(1, 5'd0, 32'h404, 0, 0, 5'd0, 32'h0, 0));
        // JALR: imm[20:12] ignored, base + offset wraps to 0
        add(st(0, 1, JALR, 32'h404, 21'h1FF010, 5'd6, 5'd9, 32'h0),
            ex(1, 5'd9, 32'h404, 0, 0, 5'd0, 32'h0, 0));
        add(st(0, 0, JMP_NOP, 32'h0, 21'h0, 5'd0, 5'd0, 32'hFFFF_FFF1),
            ex(0, 5'd0, 32'h0, 1, 1, 5'd6, 32'h408, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'h0, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0));
        // Code 2'b11 behaves as NOP
        add(st(1, 1, 2'b11, 32'h0, 21'h40, 5'd1, 5'd3, 32'h0),
            ex(1, 5'd0, 32'h4, 0, 0, 5'd0, 32'h0, 0));
        // JAL wins over seq_advance; fetch advances from the target during flush
        add(st(1, 1, JAL, 32'h4, 21'h8, 5'd0, 5'd0, 32'h0),
            ex(1, 5'd0, 32'hC, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b1), ex(1, 5'd0, 32'h10, 1, 0, 5'd0, 32'h0, 0));
        add(idle(1'b0), ex(1, 5'd0, 32'h10, 0, 0, 5'd0, 32'h0, 0));

        rst = 1'b1;
        drive(idle(1'b0));
        repeat (2) @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset flush", flush, 1'b0);
        check("reset wb_valid", wb_valid, 1'b0);
        check("reset wb_rd", wb_rd, 5'd0);
        check("reset wb_data", wb_data, 32'h0);
        check("reset misaligned", misaligned_exc, 1'b0);
        rst = 1'b0;
        #1;
        check("reset inst_ready", inst_ready, 1'b1);
        check("reset rf_rs1_addr", rf_rs1_addr, 5'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].s);
            #1;
            check($sformatf("v%0d inst_ready", i), inst_ready, vecs[i].e.rdy);
            check($sformatf("v%0d rf_rs1_addr", i), rf_rs1_addr, vecs[i].e.addr);
            sb.push_back(vecs[i].e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d pc", i), pc, e.pc);
            check($sformatf("v%0d flush", i), flush, e.fl);
            check($sformatf("v%0d wb_valid", i), wb_valid, e.wbv);
            check($sformatf("v%0d misaligned", i), misaligned_exc, e.mis);
            if (e.wbv) begin
                check($sformatf("v%0d wb_rd", i), wb_rd, e.wrd);
                check($sformatf("v%0d wb_data", i), wb_data, e.wdat);
            end
        end

        // Reset while waiting for rs1: the JALR is abandoned
        drive(st(1, 1, JALR, 32'h10, 21'h0, 5'd3, 5'd5, 32'h0));
        @(negedge clk);
        drive(st(1, 0, JMP_NOP, 32'h0, 21'h0, 5'd0, 5'd0, 32'h3000));
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait pc", pc, 32'h0);
        check("rst_wait wb_valid", wb_valid, 1'b0);
        check("rst_wait misaligned", misaligned_exc, 1'b0);
        check("rst_wait flush", flush, 1'b0);
        check("rst_wait inst_ready", inst_ready, 1'b1);
        drive(st(0, 1, JALR, 32'h0, 21'h0, 5'd3, 5'd5, 32'h0));
        #1;
        check("rst_wait rf_rs1_addr", rf_rs1_addr, 5'd0);
        rst = 1'b0;
        drive(idle(1'b0));
        @(negedge clk);
        check("rst_wait after wb_valid", wb_valid, 1'b0);
        check("rst_wait after pc", pc, 32'h0);

        // Reset during flush window
        drive(st(0, 1, JAL, 32'h0, 21'h100, 5'd2, 5'd0, 32'h0));
        @(negedge clk);
        check("rst_flush pre flush", flush, 1'b1);
        check("rst_flush pre pc", pc, 32'h100);
        drive(idle(1'b0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_flush flush", flush, 1'b0);
        check("rst_flush pc", pc, 32'h0);
        check("rst_flush wb_valid", wb_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush after flush", flush, 1'b0);
        check("rst_flush after wb_valid", wb_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
